// File: rtl/tile_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tile_sequencer_pkg                                              |
// | Purpose  : Shared widths, FSM state encoding and helpers for the tile      |
// |            sequencer slice (interface, counter and top).                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tile_sequencer_pkg;

  localparam int A_W     = 8;
  localparam int B_W     = 19;
  localparam int D_W     = 71;
  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Saturating increment for the 32-bit performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tile_sequencer_if                                               |
// | Purpose  : Command and operand-beat channels of the tile sequencer.        |
// |   cmd_valid/cmd_ready : command handshake                                  |
// |   cmd_rows            : compute rows minus one                             |
// |   cmd_shift           : output shift for the command                       |
// |   cmd_preload         : one preload beat of d precedes compute             |
// |   op_valid/op_ready   : operand beat handshake                             |
// |   op_a/op_b/op_d      : operand beat payload                               |
// |   master = producer of commands/operands, slave = the sequencer            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface tile_sequencer_if
  import tile_sequencer_pkg::*;
#(
  parameter int ROWS_W = 8
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [ROWS_W-1:0]  cmd_rows;
  logic [SHIFT_W-1:0] cmd_shift;
  logic               cmd_preload;

  logic               op_valid;
  logic               op_ready;
  logic [A_W-1:0]     op_a;
  logic [B_W-1:0]     op_b;
  logic [D_W-1:0]     op_d;

  modport master (
    output cmd_valid, cmd_rows, cmd_shift, cmd_preload,
    output op_valid, op_a, op_b, op_d,
    input  cmd_ready, op_ready
  );

  modport slave (
    input  cmd_valid, cmd_rows, cmd_shift, cmd_preload,
    input  op_valid, op_a, op_b, op_d,
    output cmd_ready, op_ready
  );

endinterface
`default_nettype wire

// File: rtl/tile_seq_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tile_seq_counter                                                |
// | Purpose  : Loadable up-counter with a terminal-value compare.              |
// |   clock, reset : clock and synchronous active-high reset                   |
// |   load/load_val: load a start value (priority over inc)                    |
// |   inc          : increment by one                                          |
// |   term         : terminal value; at_term = (count == term)                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tile_seq_counter #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_term = (count_q == term);

endmodule
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tile_sequencer                                                  |
// | Purpose  : Sequences one command into an optional preload beat followed   |
// |            by rows+1 compute beats to a PE tile, then waits for rows+1     |
// |            results before pulsing done.                                    |
// |   clock, reset          : single clock, synchronous active-high reset      |
// |   bus (slave)           : command and operand channels                     |
// |   tile_in_*             : registered drive into the PE tile                |
// |   tile_out_valid/_c     : tile results                                     |
// |   res_valid/res_c       : combinational pass-through of tile results       |
// |   done                  : one-cycle pulse at command completion            |
// |   Build macro TILE_SEQ_PERF_EN adds perf_busy_cycles / perf_stall_cycles.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tile_sequencer
  import tile_sequencer_pkg::*;
#(
  parameter int ROWS_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  tile_sequencer_if.slave    bus,
  output logic [A_W-1:0]     tile_in_a,
  output logic [B_W-1:0]     tile_in_b,
  output logic [D_W-1:0]     tile_in_d,
  output logic               tile_in_control_propagate,
  output logic [SHIFT_W-1:0] tile_in_control_shift,
  output logic               tile_in_valid,
  input  logic               tile_out_valid,
  input  logic [D_W-1:0]     tile_out_c,
  output logic               res_valid,
  output logic [D_W-1:0]     res_c,
  output logic               done
`ifdef TILE_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_busy_cycles,
  output logic [31:0]        perf_stall_cycles
`endif
);

  // One extra bit so rows = 2^ROWS_W-1 can count rows+1 without wrapping.
  localparam int CNT_W = ROWS_W + 1;

  state_t             state_q,     state_d;
  logic [ROWS_W-1:0]  rows_q,      rows_d;
  logic [SHIFT_W-1:0] shift_q,     shift_d;
  logic               prop_q,      prop_d;
  logic [A_W-1:0]     a_q,         a_d;
  logic [B_W-1:0]     b_q,         b_d;
  logic [D_W-1:0]     d_q,         d_d;
  logic [SHIFT_W-1:0] out_shift_q, out_shift_d;
  logic               out_prop_q,  out_prop_d;
  logic               valid_q,     valid_d;
  logic               done_q,      done_d;

  logic               cmd_fire;
  logic               op_fire;
  logic               iss_inc;
  logic               ret_inc;
  logic               iss_last;
  logic               ret_last;
  logic [CNT_W-1:0]   iss_term;
  logic [CNT_W-1:0]   ret_term;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.op_ready  = (state_q == ST_PRELOAD) || (state_q == ST_COMPUTE);

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign op_fire  = bus.op_valid && bus.op_ready;
  assign iss_inc  = (state_q == ST_COMPUTE) && op_fire;
  // Results that show up while idle are passed through but never counted.
  assign ret_inc  = tile_out_valid && ((state_q == ST_COMPUTE) || (state_q == ST_DRAIN));

  // Issue terminal is compared before the increment, so matching rows means
  // the beat being accepted now is beat rows+1.
  assign iss_term = {1'b0, rows_q};
  assign ret_term = iss_term + CNT_W'(1);

  tile_seq_counter #(.W(CNT_W)) u_issue_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cmd_fire),
    .load_val ('0),
    .inc      (iss_inc),
    .term     (iss_term),
    .at_term  (iss_last)
  );

  tile_seq_counter #(.W(CNT_W)) u_return_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cmd_fire),
    .load_val ('0),
    .inc      (ret_inc),
    .term     (ret_term),
    .at_term  (ret_last)
  );

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    shift_d     = shift_q;
    prop_d      = prop_q;
    a_d         = a_q;
    b_d         = b_q;
    d_d         = d_q;
    out_shift_d = out_shift_q;
    out_prop_d  = out_prop_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          rows_d  = bus.cmd_rows;
          shift_d = bus.cmd_shift;
          if (bus.cmd_preload) begin
            // Preloading flips the double-buffer select for the new command.
            prop_d  = ~prop_q;
            state_d = ST_PRELOAD;
          end else begin
            state_d = ST_COMPUTE;
          end
        end
      end
      ST_PRELOAD: begin
        if (op_fire) begin
          d_d         = bus.op_d;
          out_shift_d = shift_q;
          out_prop_d  = prop_q;
          state_d     = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (op_fire) begin
          a_d         = bus.op_a;
          b_d         = bus.op_b;
          d_d         = bus.op_d;
          valid_d     = 1'b1;
          out_shift_d = shift_q;
          out_prop_d  = prop_q;
          if (iss_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (ret_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      shift_q     <= '0;
      prop_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      out_shift_q <= '0;
      out_prop_q  <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      shift_q     <= shift_d;
      prop_q      <= prop_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      out_shift_q <= out_shift_d;
      out_prop_q  <= out_prop_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign tile_in_a                 = a_q;
  assign tile_in_b                 = b_q;
  assign tile_in_d                 = d_q;
  assign tile_in_control_shift     = out_shift_q;
  assign tile_in_control_propagate = out_prop_q;
  assign tile_in_valid             = valid_q;
  assign done                      = done_q;

  assign res_valid = tile_out_valid;
  assign res_c     = tile_out_c;

`ifdef TILE_SEQ_PERF_EN
  logic [31:0] busy_q,  busy_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (state_q != ST_IDLE) begin
      busy_d = sat_inc(busy_q);
    end
    if (bus.op_ready && !bus.op_valid) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cycles  = busy_q;
  assign perf_stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tile_sequencer                                               |
// | Purpose  : Self-checking bench for tile_sequencer. Compute beats are       |
// |            pushed to a scoreboard queue when driven and popped when the    |
// |            tile input shows them; a loopback returns each beat as a result.|
// |            Build macro TILE_SEQ_PERF_EN enables the perf-counter checks.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tile_sequencer;
  import tile_sequencer_pkg::*;

  typedef struct packed {
    logic [A_W-1:0]     a;
    logic [B_W-1:0]     b;
    logic [D_W-1:0]     d;
    logic [SHIFT_W-1:0] sh;
    logic               pr;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_sequencer_if #(.ROWS_W(8)) bus ();

  logic [A_W-1:0]     tile_in_a;
  logic [B_W-1:0]     tile_in_b;
  logic [D_W-1:0]     tile_in_d;
  logic               tile_in_control_propagate;
  logic [SHIFT_W-1:0] tile_in_control_shift;
  logic               tile_in_valid;
  logic               tile_out_valid;
  logic [D_W-1:0]     tile_out_c;
  logic               res_valid;
  logic [D_W-1:0]     res_c;
  logic               done;
`ifdef TILE_SEQ_PERF_EN
  logic [31:0]        perf_busy_cycles;
  logic [31:0]        perf_stall_cycles;
`endif

  tile_sequencer #(.ROWS_W(8)) dut (
    .clock                     (clk),
    .reset                     (rst),
    .bus                       (bus),
    .tile_in_a                 (tile_in_a),
    .tile_in_b                 (tile_in_b),
    .tile_in_d                 (tile_in_d),
    .tile_in_control_propagate (tile_in_control_propagate),
    .tile_in_control_shift     (tile_in_control_shift),
    .tile_in_valid             (tile_in_valid),
    .tile_out_valid            (tile_out_valid),
    .tile_out_c                (tile_out_c),
    .res_valid                 (res_valid),
    .res_c                     (res_c),
    .done                      (done)
`ifdef TILE_SEQ_PERF_EN
    ,
    .perf_busy_cycles          (perf_busy_cycles),
    .perf_stall_cycles         (perf_stall_cycles)
`endif
  );

  int    n_cmp   = 0;
  int    n_err   = 0;
  int    n_beats = 0;
  int    ret_cnt = 0;
  int    exp_ret = -1;
  bit    exp_prop = 1'b0;
  bit    inj = 1'b0;
  logic [SHIFT_W-1:0] exp_shift = '0;
  beat_t sb[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tile model: each issued beat comes back as a result half a cycle later.
  initial begin
    tile_out_valid = 1'b0;
    tile_out_c     = '0;
    forever begin
      @(negedge clk);
      tile_out_valid = inj | tile_in_valid;
      tile_out_c     = tile_in_d ^ 71'h55AA_1234;
    end
  end

  // Monitor: scoreboard pops, result pass-through and done-vs-returns.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (tile_in_valid) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_beat: observed a=%0h expected no beat", tile_in_a);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("tile_in_a", tile_in_a, e.a);
          check("tile_in_b", tile_in_b, e.b);
          check("tile_in_d", tile_in_d, e.d);
          check("tile_in_shift", tile_in_control_shift, e.sh);
          check("tile_in_propagate", tile_in_control_propagate, e.pr);
          n_beats++;
        end
      end
      check("res_valid", res_valid, tile_out_valid);
      if (tile_out_valid) begin
        check("res_c", res_c, tile_out_c);
        ret_cnt++;
      end
      if (done) check("done_at_returns", ret_cnt, exp_ret);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_ret = -1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_op_ready", bus.op_ready, 1'b0);
    check("rst_tile_valid", tile_in_valid, 1'b0);
    check("rst_tile_a", tile_in_a, '0);
    check("rst_tile_b", tile_in_b, '0);
    check("rst_tile_d", tile_in_d, '0);
    check("rst_shift", tile_in_control_shift, '0);
    check("rst_propagate", tile_in_control_propagate, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    exp_prop = 1'b0;
    sb.delete();
  endtask

  // Called and returns at a falling edge.
  task automatic send_cmd(input int rows, input int sh, input bit pre);
    int t = 0;
    while (!bus.cmd_ready && t < 100) begin @(negedge clk); t++; end
    n_cmp++;
    assert (t < 100) else begin n_err++; $error("FAIL cmd_ready_timeout: observed 0 expected 1"); end
    bus.cmd_valid   = 1'b1;
    bus.cmd_rows    = 8'(rows);
    bus.cmd_shift   = 5'(sh);
    bus.cmd_preload = pre;
    exp_shift = 5'(sh);
    if (pre) exp_prop = ~exp_prop;
    ret_cnt = 0;
    exp_ret = rows + 1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_op(input bit pre);
    int t = 0;
    logic [95:0] r = {$urandom(), $urandom(), $urandom()};
    logic [A_W-1:0] a = r[7:0];
    logic [B_W-1:0] b = r[26:8];
    logic [D_W-1:0] d = {r[95:25], 1'b0} ^ {r[70:0]};
    beat_t e;
    bus.op_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_d = d;
    while (!bus.op_ready && t < 100) begin @(negedge clk); t++; end
    n_cmp++;
    assert (t < 100) else begin n_err++; $error("FAIL op_ready_timeout: observed 0 expected 1"); end
    if (!pre) begin
      e.a = a; e.b = b; e.d = d; e.sh = exp_shift; e.pr = exp_prop;
      sb.push_back(e);
    end
    @(negedge clk);
    if (pre) begin
      check("preload_valid", tile_in_valid, 1'b0);
      check("preload_d", tile_in_d, d);
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    n_cmp++;
    assert (done === 1'b1) else begin n_err++; $error("FAIL done_timeout: observed 0 expected 1"); end
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);
  endtask

  task automatic run_cmd(input int rows, input int sh, input bit pre);
    int b0 = n_beats;
    send_cmd(rows, sh, pre);
    if (pre) send_op(1'b1);
    for (int i = 0; i <= rows; i++) send_op(1'b0);
    check("drain_op_ready", bus.op_ready, 1'b0);
    check("busy_cmd_ready", bus.cmd_ready, 1'b0);
    wait_done();
    check("beats_issued", n_beats - b0, rows + 1);
  endtask

  initial begin
    int b0;
    bus.cmd_valid = 1'b0; bus.cmd_rows = '0; bus.cmd_shift = '0; bus.cmd_preload = 1'b0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_d = '0;

    // Preload + 4 compute beats, shift 4.
    do_reset();
    run_cmd(3, 4, 1'b1);

    // Double-buffer select: preload, preload, no preload.
    do_reset();
    run_cmd(1, 3, 1'b1);
    run_cmd(1, 5, 1'b1);
    run_cmd(1, 6, 1'b0);

    // Single row with gapped operands; later op_valid must not issue.
    send_cmd(0, 1, 1'b0);
    b0 = n_beats;
    @(negedge clk);
    check("gap_tile_valid", tile_in_valid, 1'b0);
    send_op(1'b0);
    @(negedge clk);
    bus.op_valid = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("gap_op_ready", bus.op_ready, 1'b0);
    wait_done();
    check("gap_beats", n_beats - b0, 1);

    // Results while idle pass through but do not affect the next command.
    inj = 1'b1;
    repeat (2) @(negedge clk);
    inj = 1'b0;
    @(negedge clk);
    run_cmd(0, 2, 1'b0);

    // Full-range row count.
    run_cmd(255, 31, 1'b0);

    // Reset in the cycle of the second compute beat.
    do_reset();
    send_cmd(3, 7, 1'b0);
    send_op(1'b0);
    bus.op_valid = 1'b1;
    rst = 1'b1;
    exp_ret = -1;
    @(posedge clk);
    #1;
    check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
    check("midrst_op_ready", bus.op_ready, 1'b0);
    check("midrst_tile_valid", tile_in_valid, 1'b0);
    check("midrst_tile_a", tile_in_a, '0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    sb.delete();
    exp_prop = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_done", done, 1'b0);
    check("midrst_idle", bus.cmd_ready, 1'b1);

`ifdef TILE_SEQ_PERF_EN
    // Two rows with three operand stall cycles between them.
    send_cmd(1, 0, 1'b0);
    send_op(1'b0);
    repeat (3) @(negedge clk);
    send_op(1'b0);
    wait_done();
    check("perf_stall", perf_stall_cycles, 32'd3);
    check("perf_busy", perf_busy_cycles, 32'd7);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have parameter ROWS_W, default 8, width of the per-command row count.
REQ-002 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-005 SHALL have port cmd_rows  input  ROWS_W  compute rows minus one (0 means 1 row).
REQ-006 SHALL have port cmd_shift  input  5  output shift for this command.
REQ-007 SHALL have port cmd_preload  input  1  1: one preload beat of d precedes compute.
REQ-008 SHALL have port op_valid/op_ready  input/output  1/1  operand beat handshake.
REQ-009 SHALL have ports op_a/op_b/op_d  input  8/19/71  operand beat.
REQ-010 SHALL have ports tile_in_a/tile_in_b/tile_in_d  output  8/19/71  drive to PE tile.
REQ-011 SHALL have ports tile_in_control_propagate/tile_in_control_shift/tile_in_valid  output  1/5/1.
REQ-012 SHALL have ports tile_out_valid  input  1, tile_out_c  input  71  tile result.
REQ-013 SHALL have ports res_valid  output  1, res_c  output  71, done  output  1.

Function
REQ-014 SHALL implement states IDLE, PRELOAD, COMPUTE, DRAIN.
REQ-015 IDLE: cmd_ready=1; on cmd_valid latch rows/shift/preload; go PRELOAD if cmd_preload else COMPUTE.
REQ-016 Accepting a command with cmd_preload=1 SHALL toggle the propagate register (double-buffer select); preload=0 leaves it unchanged.
REQ-017 PRELOAD: op_ready=1; on op_valid&&op_ready drive one beat with tile_in_valid=0, tile_in_d=op_d, then go COMPUTE.
REQ-018 COMPUTE: op_ready=1; each accepted beat SHALL register tile_in_a/b/d=op_a/b/d, tile_in_valid=1, shift=latched shift, propagate=register, one cycle after handshake.
REQ-019 No accepted beat SHALL yield tile_in_valid=0 next cycle, data outputs hold previous values.
REQ-020 Issue counter SHALL count accepted COMPUTE beats; after beat rows+1, go DRAIN with op_ready=0.
REQ-021 Return counter SHALL increment on each tile_out_valid in COMPUTE or DRAIN; res_valid=tile_out_valid, res_c=tile_out_c combinationally.
REQ-022 DRAIN: when return count reaches rows+1, pulse done for one cycle and return to IDLE same edge.
REQ-023 tile_out_valid in IDLE SHALL be ignored for counting (res_valid still passes through).
REQ-024 Counters SHALL be ROWS_W+1 bits; cmd_rows=2^ROWS_W-1 SHALL issue exactly 2^ROWS_W beats, no wrap.
REQ-025 cmd_ready SHALL be 0 outside IDLE; no command overlap.

Reset
REQ-026 reset SHALL force IDLE, counters 0, propagate register 0, tile_in_valid 0, tile_in_a/b/d 0, shift 0, done 0, taking priority over any handshake same cycle.
REQ-027 Reset mid-command SHALL abandon the command; no done pulse issues.

Configuration
REQ-028 With TILE_SEQ_PERF_EN defined SHALL add outputs perf_busy_cycles and perf_stall_cycles (32 bits, saturating): busy counts non-IDLE cycles, stall counts PRELOAD/COMPUTE cycles with op_valid=0; cleared by reset only.
REQ-029 Without TILE_SEQ_PERF_EN those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-030 Shared package SHALL hold state enum, widths A_W=8, B_W=19, D_W=71, SHIFT_W=5.
REQ-031 Sub-module tile_seq_counter (loadable up-counter with terminal compare) SHALL be used for issue and return counters.

Verification
REQ-032 cmd rows=3, preload=1, shift=4, continuous ops -> 1 preload beat, 4 valid beats with propagate=1, shift=4; done after 4th tile_out_valid.
REQ-033 Two back-to-back preload=1 commands -> propagate 1 then 0; preload=0 third command -> stays 0.
REQ-034 rows=0, op_valid gapped every other cycle -> tile_in_valid gaps match, exactly 1 beat issued.
REQ-035 Reset asserted during COMPUTE beat 2 -> next cycle IDLE, tile_in_valid=0, no done, cmd_ready=1.
REQ-036 rows=255 (ROWS_W=8) -> exactly 256 valid beats, DRAIN entered, done after 256 returns.
REQ-037 PERF_EN build, 3 op stall cycles in one command -> perf_stall_cycles=3.
